l1_plru_tracker: RTL and testbench
==================================

// Module: l1_plru_tracker
//
// PURPOSE
// - Per-set tree pseudo-LRU replacement tracker for a set-associative L1 cache (data or instruction).
// - The pipeline tag stage reports accesses; the L2 fill path asks for a victim way.
// - Victim way is returned one cycle after the request; hit/fill ways are then marked MRU.
//
// PARAMETERS
// - NUM_SETS  default 64  number of sets; power of two, >= 2.
// - NUM_WAYS  default 4   associativity; one of 1, 2, 4, 8.
// - SET_IDX_W (localparam) = $clog2(NUM_SETS).
// - WAY_IDX_W (localparam) = max(1, $clog2(NUM_WAYS)).
//
// PORTS
// clk                input   1          single clock, all state on posedge
// reset              input   1          async, active-low; clears all LRU state
// fill_en            input   1          cycle N: request victim for fill_set
// fill_set           input   SET_IDX_W  set being filled
// fill_way           output  WAY_IDX_W  cycle N+1: victim way for fill requested in N
// access_en          input   1          cycle N: pipeline access to access_set (read flags)
// access_set         input   SET_IDX_W  set accessed
// access_update_en   input   1          cycle N+1: access in N hit; mark access_update_way MRU
// access_update_way  input   WAY_IDX_W  way that hit
//
// BEHAVIOUR
// - State: NUM_WAYS-1 flag bits per set, held in flops (not SRAM) so that reset can clear them.
// - Reset (reset=0): all flags 0; the internal pending-request register is cleared; fill_way = 0.
// - Tree (4 ways, b[2:0]): b2 = root (0 -> pair {0,1}, 1 -> pair {2,3}); b1 picks 0/1; b0 picks 2/3.
//   - Victim: b2=0 -> (b1 ? 1 : 0); b2=1 -> (b0 ? 3 : 2).
//   - Mark way w MRU: set every node on w's path to point away from w; leave other nodes unchanged.
//     - w0 -> b2=1, b1=1; w1 -> b2=1, b1=0; w2 -> b2=0, b0=1; w3 -> b2=0, b0=0.
// - 8 ways: same rule on a 7-node heap tree. Node 0 is the root; children of node i are 2i+1 and 2i+2.
// - 2 ways: one bit = victim index; using way w sets it to ~w.
// - 1 way: no state; fill_way is constant 0.
// - Cycle N, read port:
//   - if fill_en: latch set = fill_set, was_fill = 1.
//   - else if access_en: latch set = access_set, was_fill = 0.
//   - Flags of the latched set are registered.
//   - fill_en has priority; a simultaneous access is dropped (no LRU update for it).
// - Cycle N+1:
//   - fill_way = victim(registered flags), combinational from the registered flags.
//   - Update (write at end of N+1), to the latched set only:
//     - if was_fill: mark fill_way MRU.
//     - else if access_update_en: mark access_update_way MRU.
//     - otherwise no write.
// - access_update_en without a preceding access_en/fill_en: updates the last latched set.
//   This case is legal but undefined for use; no error is raised.
// - Back-to-back requests are fully pipelined: one request per cycle, no stalls, no handshake.
//
// CONFIGURATION
// - LRU_READ_BYPASS_EN defined: a read in cycle N+1 of the set being written in N+1 returns the new flags.
//   - Back-to-back fills to the same set therefore get different victims.
// - LRU_READ_BYPASS_EN undefined: that read returns the pre-write flags.
//   - Back-to-back fills to one set may return the same way.
//
// TESTING
// 1. Reset, then fill_en on set 5 -> fill_way=0 next cycle. Repeat fills to set 5, one per 2 cycles:
//    expect ways 0, 2, 1, 3, 0 (4-way).
// 2. Fills to set 3 in consecutive cycles: with bypass -> 0 then 2; without bypass -> 0 then 0.
// 3. access_en set 7, then access_update_en way 2; then fill set 7 -> fill_way=0.
//    After fill_way=0 -> next fill gives 3.
// 4. fill_en and access_en same cycle, different sets -> only the fill set is updated.
//    The access set's next fill still returns 0.
// 5. Assert reset mid-sequence after several updates -> next fill on any set returns 0.
// 6. Sweep NUM_WAYS=1/2/8: 1 -> always 0; 2 -> alternates 0, 1; 8 -> 8 successive fills return 8 distinct ways.

Source files
------------

// File: rtl/l1_plru_tracker.sv
// l1_plru_tracker
//
// Per-set tree pseudo-LRU replacement tracker for a set-associative L1 cache.
// The pipeline tag stage reports accesses and the L2 fill path asks for a
// victim way. A request in cycle N reads the set's flags into a register.
// In cycle N+1 the victim is presented and the hit or fill way is marked MRU.
//
// Parameters
//   NUM_SETS  number of sets (power of two, >= 2)
//   NUM_WAYS  associativity (1, 2, 4 or 8)
//
// Ports
//   clk                clock, all state on posedge
//   reset              asynchronous, active-low; clears all LRU state
//   fill_en            cycle N: request a victim for fill_set
//   fill_set           set being filled
//   fill_way           cycle N+1: victim way for the fill requested in N
//   access_en          cycle N: pipeline access to access_set
//   access_set         set accessed
//   access_update_en   cycle N+1: the access in N hit; mark access_update_way MRU
//   access_update_way  way that hit
//
// Configuration macro
//   LRU_READ_BYPASS_EN  when defined, a read of the set being written in the
//                       same cycle returns the new flags. Back-to-back fills to
//                       one set then get different victims.
//
// Tree layout: the flags form a heap. Node 0 is the root, and the children of
// node i are 2i+1 (flag 0 points there) and 2i+2 (flag 1 points there).
// Leaf way w sits at heap position w + NUM_WAYS - 1.

module l1_plru_tracker #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  localparam int SET_IDX_W = $clog2(NUM_SETS),
  localparam int WAY_IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_en,
  input  logic [SET_IDX_W-1:0] fill_set,
  output logic [WAY_IDX_W-1:0] fill_way,
  input  logic                 access_en,
  input  logic [SET_IDX_W-1:0] access_set,
  input  logic                 access_update_en,
  input  logic [WAY_IDX_W-1:0] access_update_way
);

  if (NUM_WAYS == 1) begin : g_one_way
    // A direct-mapped cache has nothing to choose between, so it keeps no state.
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, fill_en, fill_set, access_en, access_set,
                             access_update_en, access_update_way};
    assign fill_way = '0;
  end else begin : g_tree
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int NODES  = NUM_WAYS - 1;

    logic [NODES-1:0]     lru_q [NUM_SETS];
    logic [NODES-1:0]     rd_flags_q;
    logic [SET_IDX_W-1:0] pend_set_q;
    logic                 was_fill_q;

    logic [SET_IDX_W-1:0] rd_set;
    logic [NODES-1:0]     rd_flags;
    logic                 wr_en;
    logic [WAY_IDX_W-1:0] wr_way;
    logic [NODES-1:0]     wr_flags;
    logic [WAY_IDX_W-1:0] victim_way;

    // Descend from the root and follow each flag. The way index is built one
    // bit per level, and that partial index also gives the node offset within
    // the level.
    function automatic logic [WAY_IDX_W-1:0] victim_of(input logic [NODES-1:0] f);
      logic [WAY_IDX_W-1:0] w;
      logic [NODES-1:0]     sh;
      int                   node;
      w = '0;
      for (int l = 0; l < LEVELS; l++) begin
        node = (1 << l) - 1 + int'(w);
        sh   = f >> node;
        w    = (w << 1) | WAY_IDX_W'(sh[0]);
      end
      return w;
    endfunction

    // Each node on the path of w points to the other subtree.
    // Nodes off the path are left unchanged.
    function automatic logic [NODES-1:0] mark_mru(input logic [NODES-1:0]     f,
                                                   input logic [WAY_IDX_W-1:0] w);
      logic [NODES-1:0]     r;
      logic [WAY_IDX_W-1:0] prefix;
      logic [WAY_IDX_W-1:0] dirv;
      int                   node;
      r = f;
      for (int l = 0; l < LEVELS; l++) begin
        prefix = w >> (LEVELS - l);
        dirv   = w >> (LEVELS - 1 - l);
        node   = (1 << l) - 1 + int'(prefix);
        if (dirv[0]) r = r & ~(NODES'(1) << node);
        else         r = r | (NODES'(1) << node);
      end
      return r;
    endfunction

    assign victim_way = victim_of(rd_flags_q);
    assign fill_way   = victim_way;

    // A fill always claims its own victim. An access_update_en that arrives
    // in the same cycle as a fill has no matching request, so it is ignored.
    assign wr_en    = was_fill_q | access_update_en;
    assign wr_way   = was_fill_q ? victim_way : access_update_way;
    assign wr_flags = mark_mru(rd_flags_q, wr_way);

    // When neither request is active, the latched set is read again. Its
    // registered flags therefore follow completed writes.
    always_comb begin
      rd_set = pend_set_q;
      if (fill_en)        rd_set = fill_set;
      else if (access_en) rd_set = access_set;
`ifdef LRU_READ_BYPASS_EN
      rd_flags = (wr_en && (rd_set == pend_set_q)) ? wr_flags : lru_q[rd_set];
`else
      rd_flags = lru_q[rd_set];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= '0;
      end else if (wr_en) begin
        lru_q[pend_set_q] <= wr_flags;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_flags_q <= '0;
        pend_set_q <= '0;
        was_fill_q <= 1'b0;
      end else begin
        rd_flags_q <= rd_flags;
        pend_set_q <= rd_set;
        was_fill_q <= fill_en;
      end
    end
  end

endmodule

// File: tb/tb_l1_plru_tracker.sv
// tb_l1_plru_tracker
//
// Drives four instances of l1_plru_tracker (1, 2, 4 and 8 ways, 64 sets) from
// shared inputs. A per-instance tree model (heap walk with parent=(n-1)/2)
// predicts each victim. Key directed cases are also checked against constants.

module tb_l1_plru_tracker;

`ifdef LRU_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       fill_en;
  logic [5:0] fill_set;
  logic       access_en;
  logic [5:0] access_set;
  logic       access_update_en;
  logic [2:0] upd_way;
  logic [0:0] fw1;
  logic [0:0] fw2;
  logic [1:0] fw4;
  logic [2:0] fw8;

  int tests;
  int failed;

  int ways [4] = '{1, 2, 4, 8};
  int exp4 [5] = '{0, 2, 1, 3, 0};
  int exp2 [5] = '{0, 1, 0, 1, 0};

  // Model state: flag trees per instance and set, plus the read register.
  bit m_mem [4][64][7];
  bit m_s   [4][7];
  int m_p;
  bit m_w;

  bit          prev_acc;
  bit          r_fe, r_ae, r_ue;
  int          r_fs, r_as, r_uw;
  logic [31:0] seen;

  always #5 clk = ~clk;

  l1_plru_tracker #(.NUM_SETS(64), .NUM_WAYS(1)) u_dut1 (
    .clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set), .fill_way(fw1),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(upd_way[0:0]));

  l1_plru_tracker #(.NUM_SETS(64), .NUM_WAYS(2)) u_dut2 (
    .clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set), .fill_way(fw2),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(upd_way[0:0]));

  l1_plru_tracker u_dut4 (
    .clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set), .fill_way(fw4),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(upd_way[1:0]));

  l1_plru_tracker #(.NUM_SETS(64), .NUM_WAYS(8)) u_dut8 (
    .clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set), .fill_way(fw8),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(upd_way));

  function automatic logic [31:0] get_fw(int k);
    case (k)
      0:       return {31'b0, fw1};
      1:       return {31'b0, fw2};
      2:       return {30'b0, fw4};
      default: return {29'b0, fw8};
    endcase
  endfunction

  function automatic int model_victim(int k);
    int n;
    int node;
    n    = ways[k];
    node = 0;
    if (n == 1) return 0;
    while (node < n - 1) node = 2 * node + 1 + int'(m_s[k][node]);
    return node - (n - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 7; i++) begin
        m_s[k][i] = 1'b0;
        for (int s = 0; s < 64; s++) m_mem[k][s][i] = 1'b0;
      end
    end
    m_p = 0;
    m_w = 1'b0;
  endtask

  task automatic model_step(input bit fe, input int fs, input bit ae, input int as_,
                            input bit ue, input int uw);
    int rd;
    rd = fe ? fs : (ae ? as_ : m_p);
    for (int k = 0; k < 4; k++) begin
      int n;
      bit do_wr;
      int wway;
      int node;
      int parent;
      bit tmp [7];
      n     = ways[k];
      do_wr = 1'b0;
      wway  = 0;
      for (int i = 0; i < 7; i++) tmp[i] = m_s[k][i];
      if (n > 1) begin
        if (m_w) begin
          wway  = model_victim(k);
          do_wr = 1'b1;
        end else if (ue) begin
          wway  = uw % n;
          do_wr = 1'b1;
        end
      end
      if (do_wr) begin
        node = wway + n - 1;
        while (node > 0) begin
          parent      = (node - 1) / 2;
          tmp[parent] = (node % 2 == 1);
          node        = parent;
        end
      end
      for (int i = 0; i < 7; i++)
        m_s[k][i] = (BYPASS && do_wr && rd == m_p) ? tmp[i] : m_mem[k][rd][i];
      if (do_wr)
        for (int i = 0; i < 7; i++) m_mem[k][m_p][i] = tmp[i];
    end
    m_p = rd;
    m_w = fe;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs and then check every victim the model predicts.
  task automatic applyStimulus(input bit fe, input int fs, input bit ae, input int as_,
                               input bit ue, input int uw);
    fill_en          = fe;
    fill_set         = 6'(fs);
    access_en        = ae;
    access_set       = 6'(as_);
    access_update_en = ue;
    upd_way          = 3'(uw);
    model_step(fe, fs, ae, as_, ue, uw);
    @(posedge clk);
    @(negedge clk);
    if (m_w)
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("model %0d-way", ways[k]), get_fw(k), model_victim(k));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic applyReset();
    #2;
    reset            = 1'b0;
    fill_en          = 1'b0;
    access_en        = 1'b0;
    access_update_en = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("reset %0d-way", ways[k]), get_fw(k), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tests            = 0;
    failed           = 0;
    prev_acc         = 1'b0;
    reset            = 1'b1;
    fill_en          = 1'b0;
    fill_set         = '0;
    access_en        = 1'b0;
    access_set       = '0;
    access_update_en = 1'b0;
    upd_way          = '0;

    applyReset();

    // Repeated fills to set 5, spaced two cycles apart.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5, 1'b0, 0, 1'b0, 0);
      checkOutput("fill seq 4-way", {30'b0, fw4}, exp4[i]);
      checkOutput("fill seq 2-way", {31'b0, fw2}, exp2[i]);
      checkOutput("fill seq 1-way", {31'b0, fw1}, 0);
      idle();
    end

    // Back-to-back fills to set 3.
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    checkOutput("b2b first", {30'b0, fw4}, 0);
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    checkOutput("b2b second", {30'b0, fw4}, BYPASS ? 2 : 0);
    idle();

    // A hit on way 2 of set 7, followed by two fills.
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 2);
    idle();
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 0);
    checkOutput("hit then fill", {30'b0, fw4}, 0);
    idle();
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 0);
    checkOutput("hit then fill 2", {30'b0, fw4}, 3);
    idle();

    // A fill and an access in the same cycle. The fill wins and the access is dropped.
    applyStimulus(1'b1, 9, 1'b1, 10, 1'b0, 0);
    checkOutput("collide fill", {30'b0, fw4}, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 3);
    idle();
    applyStimulus(1'b1, 10, 1'b0, 0, 1'b0, 0);
    checkOutput("dropped access set", {30'b0, fw4}, 0);
    idle();
    applyStimulus(1'b1, 9, 1'b0, 0, 1'b0, 0);
    checkOutput("filled set advanced", {30'b0, fw4}, 2);
    idle();

    // Randomised traffic over a few sets, checked against the model.
    for (int c = 0; c < 400; c++) begin
      r_fe = ($urandom_range(0, 2) == 0);
      r_ae = 1'(($urandom_range(0, 1)));
      r_fs = int'($urandom_range(0, 7));
      r_as = int'($urandom_range(0, 7));
      r_ue = prev_acc && ($urandom_range(0, 1) == 1);
      r_uw = int'($urandom_range(0, 7));
      applyStimulus(r_fe, r_fs, r_ae, r_as, r_ue, r_uw);
      prev_acc = r_ae && !r_fe;
    end
    idle();

    // Apply reset mid-sequence. The next fill on a set with history returns 0.
    applyReset();
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    checkOutput("post-reset 4-way", {30'b0, fw4}, 0);
    checkOutput("post-reset 8-way", {29'b0, fw8}, 0);
    checkOutput("post-reset 2-way", {31'b0, fw2}, 0);
    idle();

    // Eight successive fills to one set cover all eight ways.
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1, 1'b0, 0, 1'b0, 0);
      seen = seen | (32'd1 << fw8);
      idle();
    end
    checkOutput("8-way distinct", seen, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
